div_unit_rv: RTL and testbench

- Iterative non-restoring integer divider for the integer ALU; the next generation of the team's divider.
- Adds the following over the previous generation:
  - XLEN parametrisation.
  - Signed and unsigned DIV/DIVU/REM/REMU with RISC-V result semantics.
  - Valid/ready on both input and output sides.
  - An opaque tag and a pipeline flush.
- Sits beside the multiplier in the execute stage; one operation in flight at a time.

---
 rtl/div_unit_rv.sv | 104 ++++++++++
 tb/tb_div_unit_rv.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/div_unit_rv.sv
// div_unit_rv: iterative non-restoring divider (DIV/DIVU/REM/REMU, RISC-V semantics) with valid/ready, tag and flush.
// Ports: CLK, rst (sync, active high), flush; in_valid/in_ready, op, dividend, divisor, in_tag;
//        out_valid/out_ready, result, out_tag, div_by_zero, overflow.
// Optional DIV_EARLY_OUT_EN: requests with |dividend| < |divisor| finish in one cycle.
module div_unit_rv #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [XLEN-1:0]  dividend,
    input  logic [XLEN-1:0]  divisor,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] out_tag,
    output logic             div_by_zero,
    output logic             overflow
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CMAX = CW'(XLEN - 1);
    typedef enum logic [1:0] {IDLE, DIVIDE, CORRECT, DONE} state_t;
    state_t state, state_nx;
    logic [XLEN:0]   acc, acc_sh, acc_nx, rem_fix;
    logic [XLEN-1:0] q, dvsr, dvd_mag, dvs_mag, quot, rem, fin, spec_res;
    logic [CW-1:0]   cnt;
    logic            op_rem, neg_q, neg_r, sgn, dz, ov, eo, special, accept;
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign sgn       = ~op[0];
    assign dvd_mag   = (sgn && dividend[XLEN-1]) ? -dividend : dividend;
    assign dvs_mag   = (sgn && divisor[XLEN-1])  ? -divisor  : divisor;
    assign dz        = divisor == '0;
    assign ov        = sgn && dividend == {1'b1, {(XLEN-1){1'b0}}} && divisor == '1;
`ifdef DIV_EARLY_OUT_EN
    assign eo        = dvd_mag < dvs_mag;
`else
    assign eo        = 1'b0;
`endif
    assign special   = dz | ov | eo;
    assign accept    = in_valid & in_ready & ~flush;
    // Quotient/remainder for the one-cycle cases; early-out gives q=0, r=dividend
    assign spec_res  = dz ? (op[1] ? dividend : '1) :
                       ov ? (op[1] ? '0 : dividend) :
                            (op[1] ? dividend : '0);
    // Sign of the partial remainder before the shift picks subtract vs add;
    // the dropped top bit is harmless since the result always fits XLEN+1 bits
    assign acc_sh    = {acc[XLEN-1:0], q[XLEN-1]};
    assign acc_nx    = acc[XLEN] ? acc_sh + {1'b0, dvsr} : acc_sh - {1'b0, dvsr};
    assign rem_fix   = acc[XLEN] ? acc + {1'b0, dvsr} : acc;
    assign quot      = neg_q ? -q : q;
    assign rem       = neg_r ? -rem_fix[XLEN-1:0] : rem_fix[XLEN-1:0];
    assign fin       = op_rem ? rem : quot;
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = accept ? (special ? DONE : DIVIDE) : IDLE;
            DIVIDE:  state_nx = cnt == CMAX ? CORRECT : DIVIDE;
            CORRECT: state_nx = DONE;
            DONE:    state_nx = out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end
    always_ff @(posedge CLK) state <= rst ? IDLE : state_nx;
    always_ff @(posedge CLK) begin
        if (rst) begin
            acc         <= '0;
            q           <= '0;
            dvsr        <= '0;
            cnt         <= '0;
            op_rem      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            result      <= '0;
            out_tag     <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else if (accept) begin
            acc         <= '0;
            q           <= dvd_mag;
            dvsr        <= dvs_mag;
            cnt         <= '0;
            op_rem      <= op[1];
            neg_q       <= sgn & (dividend[XLEN-1] ^ divisor[XLEN-1]);
            neg_r       <= sgn & dividend[XLEN-1];
            out_tag     <= in_tag;
            div_by_zero <= dz;
            overflow    <= ov & ~dz;
            if (special) result <= spec_res;
        end else if (!flush && state == DIVIDE) begin
            acc <= acc_nx;
            q   <= {q[XLEN-2:0], ~acc_nx[XLEN]};
            cnt <= cnt + 1'b1;
        end else if (!flush && state == CORRECT) begin
            result <= fin;
        end
    end
endmodule

// File: tb/tb_div_unit_rv.sv
// tb_div_unit_rv: directed self-checking bench for div_unit_rv (XLEN=32, TAG_W=5).
module tb_div_unit_rv;
    logic        CLK = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, div_by_zero, overflow;
    logic [1:0]  op = 2'b00;
    logic [31:0] dividend = '0, divisor = '0, result;
    logic [4:0]  in_tag = '0, out_tag;
    int nvec = 0, nerr = 0, lat;
    logic ir_seen;
`ifdef DIV_EARLY_OUT_EN
    localparam int EO_LAT = 1;
`else
    localparam int EO_LAT = 34;
`endif
    div_unit_rv #(.XLEN(32), .TAG_W(5)) dut (
        .CLK(CLK), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .dividend(dividend), .divisor(divisor), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .out_tag(out_tag),
        .div_by_zero(div_by_zero), .overflow(overflow)
    );
    always #5 CLK = ~CLK;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    // Issue one request, scramble operands after the accept edge, wait for out_valid
    task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t);
        @(negedge CLK);
        op = o; dividend = a; divisor = b; in_tag = t; in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0; dividend = $urandom; divisor = $urandom;
        lat = 1;
        ir_seen = 1'b0;
        while (!out_valid && lat < 100) begin
            ir_seen |= in_ready;
            @(posedge CLK); #1;
            lat++;
        end
    endtask
    task automatic ack();
        @(negedge CLK) out_ready = 1'b1;
        @(posedge CLK); #1;
        out_ready = 1'b0;
        chk("ack_out_valid", 32'(out_valid), 32'd0);
    endtask
    task automatic res(input string tag, input logic [31:0] exp, input int elat,
                       input logic edz, input logic eov);
        chk({tag, "_lat"}, lat, elat);
        chk({tag, "_res"}, result, exp);
        chk({tag, "_dbz"}, 32'(div_by_zero), 32'(edz));
        chk({tag, "_ovf"}, 32'(overflow), 32'(eov));
        ack();
    endtask
    initial begin
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        @(negedge CLK) rst = 1'b0;
        run(2'b01, 32'd100, 32'd7, 5'd3);
        chk("divu100_7_ir_low", 32'(ir_seen), 32'd0);
        res("divu100_7", 32'd14, 34, 1'b0, 1'b0);
        run(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd0);
        res("rem_m7_2", 32'hFFFF_FFFF, 34, 1'b0, 1'b0);
        run(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd0);
        res("div_m7_2", 32'hFFFF_FFFD, 34, 1'b0, 1'b0);
        run(2'b00, 32'd7, 32'hFFFF_FFFE, 5'd0);
        res("div_7_m2", 32'hFFFF_FFFD, 34, 1'b0, 1'b0);
        run(2'b10, 32'd7, 32'hFFFF_FFFE, 5'd0);
        res("rem_7_m2", 32'd1, 34, 1'b0, 1'b0);
        run(2'b01, 32'd5, 32'd0, 5'd0);
        res("divu5_0", 32'hFFFF_FFFF, 1, 1'b1, 1'b0);
        run(2'b11, 32'd5, 32'd0, 5'd0);
        res("remu5_0", 32'd5, 1, 1'b1, 1'b0);
        run(2'b10, 32'hFFFF_FFFB, 32'd0, 5'd0);
        res("rem_m5_0", 32'hFFFF_FFFB, 1, 1'b1, 1'b0);
        run(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
        res("div_ovf", 32'h8000_0000, 1, 1'b0, 1'b1);
        run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
        res("rem_ovf", 32'd0, 1, 1'b0, 1'b1);
        run(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
        res("divu_big", 32'd0, EO_LAT, 1'b0, 1'b0);
        run(2'b11, 32'd3, 32'd10, 5'd0);
        res("remu3_10", 32'd3, EO_LAT, 1'b0, 1'b0);
        run(2'b01, 32'd1000, 32'd3, 5'h1A);
        chk("hold_lat", lat, 34);
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
        end
        chk("hold_res", result, 32'd333);
        chk("hold_tag", 32'(out_tag), 32'h1A);
        ack();
        chk("hold_in_ready", 32'(in_ready), 32'd1);
        run(2'b01, 32'd1000, 32'd3, 5'd0);
        chk("pre_flush_lat", lat, 34);
        ack();
        @(negedge CLK);
        op = 2'b01; dividend = 32'd1000; divisor = 32'd3; in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge CLK);
        #1 flush = 1'b1;
        @(posedge CLK); #1;
        flush = 1'b0;
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        ir_seen = 1'b0;
        repeat (40) begin
            @(posedge CLK); #1;
            ir_seen |= out_valid;
        end
        chk("flush_no_valid", 32'(ir_seen), 32'd0);
        @(negedge CLK);
        flush = 1'b1; in_valid = 1'b1; op = 2'b01; dividend = 32'd9; divisor = 32'd0;
        @(posedge CLK); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_idle_reject", 32'(in_ready), 32'd1);
        @(posedge CLK); #1;
        chk("flush_idle_no_valid", 32'(out_valid), 32'd0);
        run(2'b01, 32'd9, 32'd3, 5'd0);
        res("divu9_3", 32'd3, 34, 1'b0, 1'b0);
        @(negedge CLK);
        op = 2'b01; dividend = 32'd50; divisor = 32'd0; in_tag = 5'h11; in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        @(negedge CLK) rst = 1'b1;
        @(posedge CLK); #1;
        rst = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_result", result, 32'd0);
        chk("mid_rst_tag", 32'(out_tag), 32'd0);
        chk("mid_rst_dbz", 32'(div_by_zero), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
